// File: rtl/ms_mul_pkg.sv
// ---------------------------------------------------------------------------
// ms_mul_pkg
// Shared types and helpers for the serial multiplier operand sequencer.
//   seq_state_t  : one-hot sequencer state encoding (IDLE, CLEAR, RUN, HOLD)
//   OPCNT_W      : width of the completed-operation counter
//   wd_width()   : width of the watchdog counter for a given MAX_CYCLES
// ---------------------------------------------------------------------------
package ms_mul_pkg;

    // One-hot codes so that any corrupted (multi-hot or zero) value lands in
    // the default branch of the next-state logic and recovers to IDLE.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        CLEAR = 4'b0010,
        RUN   = 4'b0100,
        HOLD  = 4'b1000
    } seq_state_t;

    localparam int OPCNT_W = 16;

    // Counter must hold 0 .. max_cycles-1.
    function automatic int wd_width(input int max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage : ms_mul_pkg

// File: rtl/ms_mul_operand_fifo.sv
// ---------------------------------------------------------------------------
// ms_mul_operand_fifo
// Synchronous FIFO holding complete operand vectors for the sequencer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push_i         : write push_data_i (ignored when full)
//   push_data_i    : operand vector, NUM_INPUTS x DATA_WIDTH packed
//   pop_i          : discard head entry (ignored when empty)
//   full_o         : FIFO_DEPTH entries stored
//   full_next_o    : full_o as it will be after this clock edge
//   empty_o        : no entries stored
//   head_o         : oldest entry (valid when !empty_o)
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ms_mul_operand_fifo #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_i,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] push_data_i,
    input  logic                             pop_i,
    output logic                             full_o,
    output logic                             full_next_o,
    output logic                             empty_o,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] head_o
);

    localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [VEC_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign full_next_o = (count_d == CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule : ms_mul_operand_fifo

// File: rtl/ms_mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// ms_mul_operand_sequencer
// Issue stage for ms_serial_by4_mul. Buffers operand vectors, runs one
// multiply at a time (clear pulse, hold en, wait for done), and presents each
// result on a valid/ready stream. A watchdog aborts operations whose done
// never arrives; aborts are reported with out_err=1 and out_data=0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand stream handshake (in_ready registered)
//   in_data               : NUM_INPUTS x DATA_WIDTH operand vector, operand 0 in LSBs
//   mul_rst, mul_en       : multiplier reset (rst or CLEAR pulse) and enable
//   mul_data              : operand vector presented to the multiplier
//   mul_result, mul_done  : multiplier result and done level
//   out_valid/out_ready   : result stream handshake
//   out_data, out_err     : captured result, abort flag
//   busy                  : sequencer active or operands buffered
//   op_count              : completed operations including aborts (wraps)
// ---------------------------------------------------------------------------
module ms_mul_operand_sequencer
    import ms_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                             mul_rst,
    output logic                             mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data,
    input  logic [WXIP1-1:0]                 mul_result,
    input  logic                             mul_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WXIP1-1:0]                 out_data,
    output logic                             out_err,
    output logic                             busy,
    output logic [OPCNT_W-1:0]               op_count
);

    localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;
    localparam int WD_W  = wd_width(MAX_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [VEC_W-1:0]     mul_data_q, mul_data_d;
    logic                 hold_err_q, hold_err_d;
    logic                 out_valid_q, out_valid_d;
    logic [WXIP1-1:0]     out_data_q, out_data_d;
    logic                 out_err_q, out_err_d;
    logic [OPCNT_W-1:0]   op_count_q, op_count_d;
    logic                 in_ready_q;

    logic                 fifo_push, fifo_pop;
    logic                 fifo_full, fifo_full_next, fifo_empty;
    logic [VEC_W-1:0]     fifo_head;

    logic                 slot_free;
    logic                 capture;
    logic [WXIP1-1:0]     cap_data;
    logic                 cap_err;

    assign fifo_push = in_valid && in_ready_q && !fifo_full;

    ms_mul_operand_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (in_data),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .full_next_o (fifo_full_next),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Output slot can take a new result this cycle if it is empty or is being
    // drained by the consumer on the same edge.
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d    = state_q;
        wd_cnt_d   = wd_cnt_q;
        mul_data_d = mul_data_q;
        hold_err_d = hold_err_q;
        capture    = 1'b0;
        cap_data   = '0;
        cap_err    = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // Operands are latched here so they are already stable
                    // while the multiplier is being cleared.
                    mul_data_d = fifo_head;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                wd_cnt_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                // done takes priority over a watchdog expiry in the same cycle.
                if (mul_done) begin
                    if (slot_free) begin
                        capture  = 1'b1;
                        cap_data = mul_result;
                        fifo_pop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        hold_err_d = 1'b0;
                        state_d    = HOLD;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    if (slot_free) begin
                        capture  = 1'b1;
                        cap_err  = 1'b1;
                        fifo_pop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        // Keep the abort pending rather than overwrite an
                        // unconsumed result.
                        hold_err_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // en is low here, so the multiplier keeps result/done stable.
                if (slot_free) begin
                    capture  = 1'b1;
                    cap_data = hold_err_q ? '0 : mul_result;
                    cap_err  = hold_err_q;
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        op_count_d  = op_count_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = cap_data;
            out_err_d   = cap_err;
            op_count_d  = op_count_q + OPCNT_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wd_cnt_q    <= '0;
            mul_data_q  <= '0;
            hold_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            op_count_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            mul_data_q  <= mul_data_d;
            hold_err_q  <= hold_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            op_count_q  <= op_count_d;
            in_ready_q  <= !fifo_full_next;
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_rst   = rst || (state_q == CLEAR);
    assign mul_en    = (state_q == RUN);
    assign mul_data  = mul_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule : ms_mul_operand_sequencer

// File: tb/tb_ms_mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ms_mul_operand_sequencer
// Directed bench for the operand sequencer driving a behavioural multiplier
// model: done rises on the m_n-th enabled cycle, result = a*b truncated to
// WX bits, both held until the next mul_rst. Cycle numbers in the tests
// count from the cycle in which the first operand vector is offered (cycle 0).
// ---------------------------------------------------------------------------
module tb_ms_mul_operand_sequencer;

    localparam int DW = 5;
    localparam int NI = 2;
    localparam int WX = 8;
    localparam int FD = 2;
    localparam int MC = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NI*DW-1:0]   in_data = '0;
    logic               mul_rst;
    logic               mul_en;
    logic [NI*DW-1:0]   mul_data;
    logic [WX-1:0]      mul_result;
    logic               mul_done;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WX-1:0]      out_data;
    logic               out_err;
    logic               busy;
    logic [15:0]        op_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ms_mul_operand_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .WXIP1      (WX),
        .FIFO_DEPTH (FD),
        .MAX_CYCLES (MC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mul_rst    (mul_rst),
        .mul_en     (mul_en),
        .mul_data   (mul_data),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    // ---------------- behavioural multiplier ----------------
    int            m_n = 4;
    logic [15:0]   m_cnt;
    logic          m_done;
    logic [WX-1:0] m_res;
    logic [2*DW-1:0] m_prod;

    assign m_prod     = {{DW{1'b0}}, mul_data[DW-1:0]} * {{DW{1'b0}}, mul_data[2*DW-1:DW]};
    assign mul_done   = m_done;
    assign mul_result = m_res;

    always @(posedge clk) begin
        if (mul_rst) begin
            m_cnt  <= '0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (mul_en && !m_done) begin
            m_cnt <= m_cnt + 16'd1;
            if (int'(m_cnt) == m_n - 2) begin
                m_done <= 1'b1;
                m_res  <= m_prod[WX-1:0];
            end
        end
    end

    // ---------------- result monitor ----------------
    logic [WX-1:0] res_q[$];
    logic          err_q[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            res_q.push_back(out_data);
            err_q.push_back(out_err);
            $display("result #%0d: data=%0d err=%0b op_count=%0d", res_q.size(), out_data, out_err, op_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        res_q.delete();
        err_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        out_ready = 1'b0;
        repeat (2) tick();
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_vec++; if (mul_rst !== 1'b1) begin n_bad++; $display("FAIL rst_mul_rst: got %b want 1", mul_rst); end
        n_vec++; if (mul_en !== 1'b0) begin n_bad++; $display("FAIL rst_mul_en: got %b want 0", mul_en); end
        n_vec++; if (mul_data !== '0) begin n_bad++; $display("FAIL rst_mul_data: got %h want 0", mul_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
        n_vec++; if (mul_rst !== 1'b0) begin n_bad++; $display("FAIL rst_release_mul_rst: got %b want 0", mul_rst); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_busy: got %b want 0 (push during rst kept)", busy); end
    endtask

    task automatic test_single_op();
        apply_reset();
        m_n = 4;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_vec++; if (mul_en !== (c >= 3 && c <= 6)) begin n_bad++; $display("FAIL t1_mul_en c%0d: got %b want %b", c, mul_en, (c >= 3 && c <= 6)); end
            n_vec++; if (mul_rst !== (c == 2)) begin n_bad++; $display("FAIL t1_mul_rst c%0d: got %b want %b", c, mul_rst, (c == 2)); end
            if (c >= 2) begin
                n_vec++; if (mul_data !== {5'd7, 5'd3}) begin n_bad++; $display("FAIL t1_mul_data c%0d: got %h want %h", c, mul_data, {5'd7, 5'd3}); end
            end
            if (c == 1) begin
                n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_c1: got %b want 1", busy); end
            end
            if (c == 7) begin
                n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t1_out_valid: got %b want 1", out_valid); end
                n_vec++; if (out_data !== 8'd21) begin n_bad++; $display("FAIL t1_out_data: got %0d want 21", out_data); end
                n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL t1_out_err: got %b want 0", out_err); end
                n_vec++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL t1_op_count: got %0d want 1", op_count); end
                n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after: got %b want 0", busy); end
            end
            if (c == 8) begin
                n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_out_valid_drained: got %b want 0", out_valid); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t;
        apply_reset();
        m_n = 4;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t2_ready_c0: got %b want 1", in_ready); end
        tick();
        in_data = {5'd9, 5'd2};
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t2_ready_c1: got %b want 1", in_ready); end
        tick();
        in_data = {5'd31, 5'd31};
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t2_ready_full_c2: got %b want 0", in_ready); end
        t = 2;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        n_vec++; if (t != 7) begin n_bad++; $display("FAIL t2_ready_rise_cycle: got %0d want 7", t); end
        tick();
        in_valid = 1'b0;
        t = 0;
        while (res_q.size() < 3 && t < 100) begin
            tick();
            t++;
        end
        repeat (20) tick();
        n_vec++; if (res_q.size() != 3) begin n_bad++; $display("FAIL t2_result_count: got %0d want 3", res_q.size()); end
        if (res_q.size() == 3) begin
            n_vec++; if (res_q[0] !== 8'd21) begin n_bad++; $display("FAIL t2_res0: got %0d want 21", res_q[0]); end
            n_vec++; if (res_q[1] !== 8'd18) begin n_bad++; $display("FAIL t2_res1: got %0d want 18", res_q[1]); end
            n_vec++; if (res_q[2] !== 8'd193) begin n_bad++; $display("FAIL t2_res2: got %0d want 193", res_q[2]); end
            n_vec++; if ({err_q[0], err_q[1], err_q[2]} !== 3'b000) begin n_bad++; $display("FAIL t2_errs: got %b%b%b want 000", err_q[0], err_q[1], err_q[2]); end
        end
        n_vec++; if (op_count !== 16'd3) begin n_bad++; $display("FAIL t2_op_count: got %0d want 3", op_count); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_hold();
        logic exp_en;
        apply_reset();
        m_n = 4;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        tick();
        in_data = {5'd9, 5'd6};
        tick();
        in_valid = 1'b0;
        for (int c = 2; c <= 18; c++) begin
            if (c == 16) out_ready = 1'b1;
            exp_en = (c >= 3 && c <= 6) || (c >= 9 && c <= 12);
            n_vec++; if (mul_en !== exp_en) begin n_bad++; $display("FAIL t3_mul_en c%0d: got %b want %b", c, mul_en, exp_en); end
            n_vec++; if (mul_rst !== (c == 2 || c == 8)) begin n_bad++; $display("FAIL t3_mul_rst c%0d: got %b want %b", c, mul_rst, (c == 2 || c == 8)); end
            if (c >= 7 && c <= 16) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 8'd21) begin n_bad++; $display("FAIL t3_hold_first c%0d: got v=%b d=%0d want v=1 d=21", c, out_valid, out_data); end
            end
            if (c == 13) begin
                n_vec++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL t3_op_count_hold: got %0d want 1", op_count); end
            end
            if (c == 17) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 8'd54 || out_err !== 1'b0) begin n_bad++; $display("FAIL t3_second: got v=%b d=%0d e=%b want v=1 d=54 e=0", out_valid, out_data, out_err); end
                n_vec++; if (op_count !== 16'd2) begin n_bad++; $display("FAIL t3_op_count: got %0d want 2", op_count); end
            end
            if (c == 18) begin
                n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL t3_idle_end: got v=%b busy=%b want 0 0", out_valid, busy); end
            end
            tick();
        end
        n_vec++; if (res_q.size() != 2) begin n_bad++; $display("FAIL t3_result_count: got %0d want 2", res_q.size()); end
        if (res_q.size() == 2) begin
            n_vec++; if (res_q[0] !== 8'd21 || res_q[1] !== 8'd54) begin n_bad++; $display("FAIL t3_order: got %0d,%0d want 21,54", res_q[0], res_q[1]); end
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        m_n = 1000;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n_vec++; if (mul_en !== (c >= 3 && c <= 10)) begin n_bad++; $display("FAIL t4_mul_en c%0d: got %b want %b", c, mul_en, (c >= 3 && c <= 10)); end
            if (c == 11) begin
                n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin n_bad++; $display("FAIL t4_abort_flag: got v=%b e=%b want v=1 e=1", out_valid, out_err); end
                n_vec++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL t4_abort_data: got %0d want 0", out_data); end
                n_vec++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL t4_op_count: got %0d want 1", op_count); end
            end
            if (c == 12) begin
                n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t4_abort_drained: got %b want 0", out_valid); end
            end
            tick();
        end
        m_n = 4;
        in_valid = 1'b1;
        in_data = {5'd6, 5'd4};
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 8'd24 || out_err !== 1'b0) begin n_bad++; $display("FAIL t4_next_op: got v=%b d=%0d e=%b want v=1 d=24 e=0", out_valid, out_data, out_err); end
                n_vec++; if (op_count !== 16'd2) begin n_bad++; $display("FAIL t4_next_op_count: got %0d want 2", op_count); end
            end
            tick();
        end
    endtask

    task automatic test_done_vs_watchdog();
        apply_reset();
        m_n = 8;
        in_valid = 1'b1;
        in_data = {5'd5, 5'd4};
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n_vec++; if (mul_en !== (c >= 3 && c <= 10)) begin n_bad++; $display("FAIL t5_mul_en c%0d: got %b want %b", c, mul_en, (c >= 3 && c <= 10)); end
            if (c == 11) begin
                n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin n_bad++; $display("FAIL t5_done_wins: got v=%b e=%b want v=1 e=0", out_valid, out_err); end
                n_vec++; if (out_data !== 8'd20) begin n_bad++; $display("FAIL t5_data: got %0d want 20", out_data); end
            end
            tick();
        end
        n_vec++; if (res_q.size() != 1) begin n_bad++; $display("FAIL t5_result_count: got %0d want 1", res_q.size()); end
    endtask

    task automatic test_reset_mid_op();
        int stray;
        apply_reset();
        m_n = 4;
        in_valid = 1'b1;
        in_data = {5'd7, 5'd3};
        tick();
        in_data = {5'd9, 5'd6};
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        n_vec++; if (mul_en !== 1'b1) begin n_bad++; $display("FAIL t6_in_run_c4: got %b want 1", mul_en); end
        rst = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b0 || mul_rst !== 1'b1 || mul_en !== 1'b0) begin n_bad++; $display("FAIL t6_rst_ctrl: got ready=%b mrst=%b en=%b want 0 1 0", in_ready, mul_rst, mul_en); end
        n_vec++; if (mul_data !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin n_bad++; $display("FAIL t6_rst_data: got md=%h v=%b d=%0d e=%b want 0 0 0 0", mul_data, out_valid, out_data, out_err); end
        n_vec++; if (busy !== 1'b0 || op_count !== 16'd0) begin n_bad++; $display("FAIL t6_rst_status: got busy=%b cnt=%0d want 0 0", busy, op_count); end
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid || busy || mul_en) stray++;
        end
        n_vec++; if (stray != 0) begin n_bad++; $display("FAIL t6_dropped_ops: got %0d active cycles want 0", stray); end
        n_vec++; if (res_q.size() != 0) begin n_bad++; $display("FAIL t6_no_result: got %0d results want 0", res_q.size()); end
        in_valid = 1'b1;
        in_data = {5'd2, 5'd5};
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 8'd10 || out_err !== 1'b0) begin n_bad++; $display("FAIL t6_post_op: got v=%b d=%0d e=%b want v=1 d=10 e=0", out_valid, out_data, out_err); end
                n_vec++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL t6_op_count: got %0d want 1", op_count); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_hold();
        test_watchdog();
        test_done_vs_watchdog();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_ms_mul_operand_sequencer
